dmem_arbiter: RTL and testbench

- Shared data-memory responder for the multi-core cpu: accepts load/store requests from CORES core initiators and serialises them onto the single-port data memory (dm).
- Round-robin fairness; one access per cycle; registered read return to the granted core.
- Sits between the core array and dm inside cpu, replacing direct core-to-dm wiring.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto the single-port data memory.
// Optional bus locking for atomic sequences is enabled with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int CORES  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CORES-1:0]          req,
    input  logic [CORES-1:0]          we,
    input  logic [CORES*ADDR_W-1:0]   addr,
    input  logic [CORES*DATA_W-1:0]   wdata,
    input  logic [CORES-1:0]          lock,
    output logic [CORES-1:0]          gnt,
    output logic [CORES-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [PTR_W-1:0]  gidx;
    logic [PTR_W-1:0]  idx_v;
    logic              any_gnt;
    logic [CORES-1:0]  elig;
    logic [CORES-1:0]  gnt_c;
    logic [CORES-1:0]  rvalid_p1;
    logic [DATA_W-1:0] rdata_p1;

`ifdef DMEM_ARB_LOCK_EN
    logic             owner_vld;
    logic [PTR_W-1:0] owner_idx;

    // While a core owns the bus, every other request is masked off.
    always_comb begin
        elig = '0;
        for (int i = 0; i < CORES; i++) begin
            elig[i] = req[i] && (!owner_vld || owner_idx == PTR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_vld <= 1'b0;
            owner_idx <= '0;
        end else if (owner_vld) begin
            if (!lock[owner_idx]) owner_vld <= 1'b0;
        end else if (any_gnt && lock[gidx]) begin
            owner_vld <= 1'b1;
            owner_idx <= gidx;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;

    always_comb begin
        elig = req;
    end
`endif

    // Search from ptr upward with wrap-around; first eligible core wins.
    always_comb begin
        int idx;
        gnt_c   = '0;
        gidx    = '0;
        idx_v   = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < CORES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CORES) idx = idx - CORES;
            idx_v = PTR_W'(idx);
            if (!any_gnt && !reset && elig[idx_v]) begin
                any_gnt = 1'b1;
                gidx    = idx_v;
            end
        end
        if (any_gnt) gnt_c[gidx] = 1'b1;
    end

    always_comb begin
        mem_addr  = addr[0 +: ADDR_W];
        mem_wdata = wdata[0 +: DATA_W];
        mem_we    = 1'b0;
        if (any_gnt) begin
            mem_addr  = addr[gidx*ADDR_W +: ADDR_W];
            mem_wdata = wdata[gidx*DATA_W +: DATA_W];
            mem_we    = we[gidx];
        end
    end

    always_comb begin
        if (gidx == PTR_W'(CORES-1)) ptr_nxt = '0;
        else                         ptr_nxt = gidx + 1'b1;
    end

    // Stage p1: registered load return, one cycle after the load grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            rvalid_p1 <= '0;
            rdata_p1  <= '0;
        end else begin
            if (any_gnt) ptr <= ptr_nxt;
            rvalid_p1 <= mem_we ? '0 : gnt_c;
            if (any_gnt && !mem_we) rdata_p1 <= mem_rdata;
        end
    end

    assign gnt    = gnt_c;
    assign rvalid = rvalid_p1;
    assign rdata  = rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural dm model plus queued load-return expectations.
// The lock scenario runs only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    localparam int CORES  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [CORES-1:0]        req, we, lock;
    logic [CORES*ADDR_W-1:0] addr;
    logic [CORES*DATA_W-1:0] wdata;
    logic [CORES-1:0]        gnt, rvalid;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [CORES-1:0]  v;
        logic [DATA_W-1:0] d;
        int                due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    dmem_arbiter #(.CORES(CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dm model: unwritten words read a fixed pattern; word 3 holds 5.
    logic [DATA_W-1:0] dm [1<<ADDR_W];
    logic [(1<<ADDR_W)-1:0] dm_wr = '0;

    function automatic logic [DATA_W-1:0] dm_init(input logic [ADDR_W-1:0] a);
        return (a == 10'd3) ? 32'd5 : 32'(a) * 7 + 100;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            dm[mem_addr]    <= mem_wdata;
            dm_wr[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = dm_wr[mem_addr] ? dm[mem_addr] : dm_init(mem_addr);

    // Response monitor: every rvalid pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (rvalid !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_rvalid: got rvalid=%b rdata=%h, required no response", rvalid, rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rvalid !== mon_e.v || rdata !== mon_e.d || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL load_return: got rvalid=%b rdata=%h cycle=%0d, required rvalid=%b rdata=%h cycle=%0d",
                             rvalid, rdata, cyc, mon_e.v, mon_e.d, mon_e.due);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL missed_rvalid: got rvalid=%b, required rvalid=%b rdata=%h at cycle %0d",
                     rvalid, mon_e.v, mon_e.d, mon_e.due);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i]                  = r;
        we[i]                   = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_exp(input logic [CORES-1:0] v, input logic [DATA_W-1:0] d);
        exp_t e;
        e.v   = v;
        e.d   = d;
        e.due = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [CORES-1:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int               who [4] = '{1, 2, 3, 0};
        reset = 1'b1;
        for (int i = 0; i < CORES; i++) set_core(i, 1'b1, 1'b1, 10'(20 + i), 32'(32'hA0 + i));
        lock = '0;
        step();
        step();
        #1;
        checks++;
        if (gnt !== 4'b0000 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got gnt=%b mem_we=%b, required 0000/0", gnt, mem_we);
        end
        checks++;
        if (rvalid !== 4'b0000 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: got rvalid=%b rdata=%h, required 0000/0", rvalid, rdata);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0001 || mem_addr !== 10'd20 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rr_first: got gnt=%b addr=%0d we=%b, required 0001/20/1", gnt, mem_addr, mem_we);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            checks++;
            if (gnt !== seq[k] || mem_addr !== 10'(20 + who[k]) || mem_wdata !== 32'(32'hA0 + who[k])) begin
                errors++;
                $display("FAIL rr_rotate%0d: got gnt=%b addr=%0d wdata=%h, required %b/%0d/%h",
                         k, gnt, mem_addr, mem_wdata, seq[k], 20 + who[k], 32'hA0 + who[k]);
            end
        end
        step();
        req = '0;
        we  = '0;
    endtask

    task automatic test_rr_skip();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_core(1, 1'b1, 1'b0, 10'd40, 32'd0);
        set_core(3, 1'b1, 1'b0, 10'd41, 32'd0);
        #1;
        checks++;
        if (gnt !== 4'b0010 || mem_addr !== 10'd40 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL skip_core1: got gnt=%b addr=%0d we=%b, required 0010/40/0", gnt, mem_addr, mem_we);
        end
        push_exp(4'b0010, dm_init(10'd40));
        step();
        #1;
        checks++;
        if (gnt !== 4'b1000 || mem_addr !== 10'd41) begin
            errors++;
            $display("FAIL skip_core3: got gnt=%b addr=%0d, required 1000/41", gnt, mem_addr);
        end
        push_exp(4'b1000, dm_init(10'd41));
        step();
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL skip_wrap: got gnt=%b, required 0010", gnt);
        end
        push_exp(4'b0010, dm_init(10'd40));
        step();
        req = '0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL idle_gnt: got gnt=%b, required 0000", gnt);
        end
    endtask

    task automatic test_back_to_back();
        step();
        set_core(2, 1'b1, 1'b1, 10'd5, 32'd14);
        #1;
        checks++;
        if (gnt !== 4'b0100 || mem_we !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 32'd14) begin
            errors++;
            $display("FAIL b2b_store: got gnt=%b we=%b addr=%0d wdata=%h, required 0100/1/5/0000000e",
                     gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        set_core(2, 1'b1, 1'b0, 10'd5, 32'd0);
        #1;
        checks++;
        if (gnt !== 4'b0100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: got gnt=%b we=%b, required 0100/0", gnt, mem_we);
        end
        push_exp(4'b0100, 32'd14);
        step();
        req = '0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_idle: got gnt=%b we=%b, required 0000/0", gnt, mem_we);
        end
        step();
    endtask

    task automatic test_store_only();
        step();
        req = '0;
        we  = '0;
        set_core(0, 1'b0, 1'b0, 10'd77, 32'h1234);
        #1;
        checks++;
        if (gnt !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 10'd77 || mem_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL nogrant_mux: got gnt=%b we=%b addr=%0d wdata=%h, required 0000/0/77/00001234",
                     gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        set_core(3, 1'b1, 1'b1, 10'd9, 32'hDEADBEEF);
        #1;
        checks++;
        if (gnt !== 4'b1000 || mem_we !== 1'b1 || mem_addr !== 10'd9 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL core3_store: got gnt=%b we=%b addr=%0d wdata=%h, required 1000/1/9/deadbeef",
                     gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        req = '0;
        #1;
        checks++;
        if (rvalid !== 4'b0000) begin
            errors++;
            $display("FAIL store_no_rvalid: got rvalid=%b, required 0000", rvalid);
        end
    endtask

    task automatic test_reset_mid();
        step();
        set_core(0, 1'b1, 1'b0, 10'd3, 32'd0);
        #1;
        checks++;
        if (gnt !== 4'b0001 || mem_addr !== 10'd3) begin
            errors++;
            $display("FAIL mid_load_gnt: got gnt=%b addr=%0d, required 0001/3", gnt, mem_addr);
        end
        push_exp(4'b0001, 32'd5);
        step();
        req   = '0;
        reset = 1'b1;
        step();
        #1;
        checks++;
        if (rvalid !== 4'b0000 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got rvalid=%b rdata=%h, required 0000/0", rvalid, rdata);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (rvalid !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_stale: got rvalid=%b, required 0000", rvalid);
        end
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        step();
        req = '0;
        we  = '0;
        set_core(1, 1'b1, 1'b1, 10'd51, 32'd1);
        lock = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL lock_acquire: got gnt=%b, required 0010", gnt);
        end
        step();
        for (int i = 0; i < CORES; i++) set_core(i, 1'b1, 1'b1, 10'(50 + i), 32'(i));
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== 4'b0010) begin
                errors++;
                $display("FAIL lock_hold%0d: got gnt=%b, required 0010", k, gnt);
            end
            step();
        end
        lock = '0;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL lock_drop_cycle: got gnt=%b, required 0010", gnt);
        end
        step();
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL lock_release: got gnt=%b, required 0100", gnt);
        end
        step();
        req = '0;
        we  = '0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        test_reset();
        test_rr_skip();
        test_back_to_back();
        test_store_only();
        test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        step();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
